minterm_scanner: RTL and testbench
==================================

Name: minterm_scanner

Overview:
- Inverse of the team's canonical SoP/PoS combinational blocks: those build a function from a minterm list; this block takes a 3-variable truth table and emits its minterm (or maxterm) indices serially.
- Indices are streamed one at a time over a valid/ready handshake, with a term count and a done pulse.
- Feeds the display/verification side of the Boolean-function exercises, for example to print "SoP(0,2,6,7)" from a table computed in hardware.

Parameters:
- N_VARS, 3, number of function inputs. The block is specified and verified for 3 only.
- TT_W, 2**N_VARS = 8, truth-table width. Derived; do not override.

Ports:
- clk, input, 1, single clock, rising edge.
- reset, input, 1, synchronous, active-high.
- start, input, 1, one-cycle request that latches tt_in and mode. Only accepted in IDLE.
- tt_in, input, 8, truth table: tt_in[i] = f(x,y,z) with {x,y,z} = i, x is the MSB.
- mode, input, 1, 0 = list minterms (1s, SoP); 1 = list maxterms (0s, PoS).
- busy, output, 1, high while in SCAN or DONE.
- idx_valid, output, 1, idx holds a term index.
- idx_ready, input, 1, consumer accepts idx.
- idx, output, 3, current term index (0..7).
- idx_last, output, 1, qualified by idx_valid; marks the highest-numbered term.
- count, output, 4, number of terms accepted in the current or most recent scan (0..8).
- done, output, 1, one-cycle pulse when a scan finishes.

Behaviour:
- Reset (synchronous, active-high):
  - state = IDLE.
  - ptr = 0, mask = 0, count = 0.
  - Outputs busy, idx_valid, idx, idx_last, done are all 0.
- States: IDLE, SCAN, DONE.
- IDLE:
  - On start = 1, register mask = mode ? ~tt_in : tt_in, set ptr = 0, count = 0, and go to SCAN.
  - start is ignored in SCAN and DONE.
- SCAN, one bit position per cycle minimum:
  - idx = ptr.
  - idx_valid = mask[ptr]. Driven from registered state only (Moore); no combinational path from idx_ready to idx_valid or idx.
  - idx_last = mask[ptr] and no bits of mask above ptr are set.
  - If mask[ptr] = 0: advance ptr the next cycle (skip).
  - If mask[ptr] = 1: hold ptr, idx and idx_valid until idx_ready = 1. On the handshake cycle, increment count and advance ptr.
  - Stall has no timeout; idx/idx_valid/idx_last must stay stable while idx_ready = 0.
  - When ptr = 7 advances (skip or handshake), go to DONE. ptr does not wrap.
- DONE: done = 1 for exactly one cycle, busy = 1, idx_valid = 0. Return to IDLE.
- count holds its final value in IDLE until the next accepted start.
- Timing with idx_ready held at 1:
  - start in cycle t gives SCAN with ptr = 0 at t+1.
  - The last bit is examined at t+8.
  - done = 1 at t+9.
  - Total latency is 9 cycles regardless of the table contents.
- Each stalled cycle adds exactly one cycle to that latency.
- Empty mask (tt_in = 00 in mode 0, or FF in mode 1): 8 skip cycles, no idx_valid, count = 0, done at t+9.
- Full mask: 8 consecutive terms, count = 8 (4-bit, no overflow).
- start and reset in the same cycle: reset wins.
- reset mid-scan or mid-stall: back to IDLE with all outputs zero next cycle. No done pulse is issued.

Test Plan:
- Minterm listing: tt_in = 8'b1100_0101, mode = 0, idx_ready = 1, start at cycle 0 → idx 0, 2, 6, 7 valid at cycles 1, 3, 7, 8; idx_last only with idx 7; done at cycle 9; count = 4.
- Maxterm listing: same tt_in, mode = 1 → idx 1, 3, 4, 5 at cycles 2, 4, 5, 6; idx_last with 5; count = 4; done at cycle 9.
- Backpressure: tt_in = 8'hFF, mode = 0, idx_ready low for 3 cycles on idx 2 → idx 2 held stable for 4 cycles; all 8 indices in order; count = 8; done at cycle 12.
- Empty table: tt_in = 8'h00, mode = 0 → idx_valid never asserted; busy high cycles 1–9; done at cycle 9; count = 0.
- Reset mid-scan: tt_in = 8'hAA, reset at cycle 4 → cycle 5 shows IDLE, all outputs 0, no done; a new start then scans normally (idx 1, 3, 5, 7; count = 4).
- start while busy: a second start at cycle 3 with tt_in = 8'h0F → ignored; the original scan completes unchanged.

Source files
------------

// File: rtl/minterm_scanner.sv
`default_nettype none
// ============================================================================
//  Module   : minterm_scanner
//  Brief    : Takes an N_VARS-input truth table and streams the indices of its
//             minterms (mode=0) or maxterms (mode=1) over a valid/ready
//             handshake. It also reports the term count and pulses done when
//             the scan is finished.
//  Revision : 1.0 - initial release
// ============================================================================
module minterm_scanner #(
   parameter int N_VARS = 3,
   parameter int TT_W   = 2 ** N_VARS
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [TT_W-1:0]   tt_in,
   input  logic              mode,
   output logic              busy,
   output logic              idx_valid,
   input  logic              idx_ready,
   output logic [N_VARS-1:0] idx,
   output logic              idx_last,
   output logic [N_VARS:0]   count,
   output logic              done
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_SCAN = 2'd1,
      S_DONE = 2'd2
   } state_t;

   localparam logic [N_VARS-1:0] c_last_ptr = N_VARS'(TT_W - 1);
   localparam logic [N_VARS-1:0] c_ptr_one  = N_VARS'(1);
   localparam logic [N_VARS:0]   c_cnt_one  = (N_VARS + 1)'(1);
   localparam logic [TT_W-1:0]   c_bit0     = TT_W'(1);

   state_t              r_state;
   logic [N_VARS-1:0]   r_ptr;
   logic [TT_W-1:0]     r_mask;
   logic [N_VARS:0]     r_count;

   logic                w_scan;
   logic                w_hit;
   logic [TT_W-1:0]     w_upper;
   logic                w_advance;

   // Term presence and "no higher term" detection from registered state only,
   // so idx_valid/idx/idx_last never depend on idx_ready.
   assign w_scan    = (r_state == S_SCAN);
   assign w_hit     = w_scan & r_mask[r_ptr];
   assign w_upper   = r_mask >> r_ptr;
   assign w_advance = w_scan & (~r_mask[r_ptr] | idx_ready);

   assign busy      = (r_state != S_IDLE);
   assign idx_valid = w_hit;
   assign idx       = w_scan ? r_ptr : '0;
   assign idx_last  = w_hit & (w_upper == c_bit0);
   assign count     = r_count;
   assign done      = (r_state == S_DONE);

   // Scan controller: latch the term mask on start, then walk the mask one bit
   // per cycle, holding the pointer on a set bit until it is accepted.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_ptr   <= '0;
         r_mask  <= '0;
         r_count <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_mask  <= mode ? ~tt_in : tt_in;
                  r_ptr   <= '0;
                  r_count <= '0;
                  r_state <= S_SCAN;
               end
            end
            S_SCAN: begin
               if (w_advance) begin
                  if (w_hit) begin
                     r_count <= r_count + c_cnt_one;
                  end
                  // The pointer stops at the last position instead of
                  // wrapping; idx is gated to zero outside SCAN anyway.
                  if (r_ptr == c_last_ptr) begin
                     r_state <= S_DONE;
                  end else begin
                     r_ptr <= r_ptr + c_ptr_one;
                  end
               end
            end
            S_DONE: begin
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_minterm_scanner.sv
`default_nettype none
// ============================================================================
//  Module   : tb_minterm_scanner
//  Brief    : Directed scoreboard bench for minterm_scanner.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_minterm_scanner;

   logic       clk;
   logic       reset;
   logic       start;
   logic [7:0] tt_in;
   logic       mode;
   logic       busy;
   logic       idx_valid;
   logic       idx_ready;
   logic [2:0] idx;
   logic       idx_last;
   logic [3:0] count;
   logic       done;

   minterm_scanner #(.N_VARS(3)) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .tt_in     (tt_in),
      .mode      (mode),
      .busy      (busy),
      .idx_valid (idx_valid),
      .idx_ready (idx_ready),
      .idx       (idx),
      .idx_last  (idx_last),
      .count     (count),
      .done      (done)
   );

   typedef struct packed {
      logic [2:0]  idx;
      logic        last;
      logic [31:0] cyc;
   } idx_exp_t;

   typedef struct packed {
      logic [3:0]  cnt;
      logic [31:0] cyc;
   } done_exp_t;

   idx_exp_t  q_idx[$];
   done_exp_t q_done[$];

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   int base   = 0;
   int rel_m;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Free-running edge counter; the scan-relative cycle is cyc - base.
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc - base);
      end
   endtask

   function automatic void push_idx(input logic [2:0] i, input logic l, input int c);
      idx_exp_t e;
      e.idx  = i;
      e.last = l;
      e.cyc  = c;
      q_idx.push_back(e);
   endfunction

   function automatic void push_done(input logic [3:0] n, input int c);
      done_exp_t e;
      e.cnt = n;
      e.cyc = c;
      q_done.push_back(e);
   endfunction

   // Monitor: compares presented terms and done pulses against the scoreboard.
   always @(negedge clk) begin
      idx_exp_t  ei;
      done_exp_t ed;
      rel_m = cyc - base;
      if (idx_valid === 1'b1) begin
         if (q_idx.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_idx: got idx %0d with nothing expected (cycle %0d)", idx, rel_m);
         end else if (idx_ready) begin
            ei = q_idx.pop_front();
            chk("idx", {29'b0, idx}, {29'b0, ei.idx});
            chk("idx_last", {31'b0, idx_last}, {31'b0, ei.last});
            chk("idx_cycle", rel_m, ei.cyc);
         end else begin
            ei = q_idx[0];
            chk("stall_idx", {29'b0, idx}, {29'b0, ei.idx});
            chk("stall_last", {31'b0, idx_last}, {31'b0, ei.last});
         end
      end
      if (done === 1'b1) begin
         if (q_done.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: got done with nothing expected (cycle %0d)", rel_m);
         end else begin
            ed = q_done.pop_front();
            chk("done_cycle", rel_m, ed.cyc);
            chk("done_count", {28'b0, count}, {28'b0, ed.cnt});
            chk("done_busy", {31'b0, busy}, 32'd1);
         end
      end
   end

   // All driver tasks assume they are entered just after a rising edge.
   task automatic start_scan(input logic [7:0] tt, input logic m);
      tt_in = tt;
      mode  = m;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      base  = cyc - 1;
   endtask

   task automatic wait_rel(input int n);
      int guard = 0;
      while (((cyc - base) < n) && (guard < 100)) begin
         @(posedge clk);
         #1;
         guard++;
      end
   endtask

   task automatic drain();
      int guard = 0;
      while (((q_idx.size() != 0) || (q_done.size() != 0)) && (guard < 60)) begin
         @(posedge clk);
         #1;
         guard++;
      end
      checks++;
      if ((q_idx.size() != 0) || (q_done.size() != 0)) begin
         errors++;
         $display("FAIL drain: got %0d terms and %0d done pulses outstanding expected 0",
                  q_idx.size(), q_done.size());
         q_idx.delete();
         q_done.delete();
      end
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic chk_idle_zero(input string tag);
      chk({tag, "_busy"}, {31'b0, busy}, 32'd0);
      chk({tag, "_valid"}, {31'b0, idx_valid}, 32'd0);
      chk({tag, "_idx"}, {29'b0, idx}, 32'd0);
      chk({tag, "_last"}, {31'b0, idx_last}, 32'd0);
      chk({tag, "_done"}, {31'b0, done}, 32'd0);
      chk({tag, "_count"}, {28'b0, count}, 32'd0);
   endtask

   initial begin
      reset     = 1'b1;
      start     = 1'b0;
      tt_in     = 8'h00;
      mode      = 1'b0;
      idx_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk_idle_zero("reset");
      reset = 1'b0;
      @(posedge clk);
      #1;

      // Minterms of 1100_0101: 0, 2, 6, 7.
      push_idx(3'd0, 1'b0, 1);
      push_idx(3'd2, 1'b0, 3);
      push_idx(3'd6, 1'b0, 7);
      push_idx(3'd7, 1'b1, 8);
      push_done(4'd4, 9);
      start_scan(8'b1100_0101, 1'b0);
      drain();
      chk("count_hold", {28'b0, count}, 32'd4);
      chk("idle_busy", {31'b0, busy}, 32'd0);

      // Maxterms of the same table: 1, 3, 4, 5.
      push_idx(3'd1, 1'b0, 2);
      push_idx(3'd3, 1'b0, 4);
      push_idx(3'd4, 1'b0, 5);
      push_idx(3'd5, 1'b1, 6);
      push_done(4'd4, 9);
      start_scan(8'b1100_0101, 1'b1);
      drain();

      // Full table with a 3-cycle stall on idx 2.
      push_idx(3'd0, 1'b0, 1);
      push_idx(3'd1, 1'b0, 2);
      push_idx(3'd2, 1'b0, 6);
      for (int i = 3; i < 8; i++) push_idx(3'(i), (i == 7), i + 4);
      push_done(4'd8, 12);
      start_scan(8'hFF, 1'b0);
      wait_rel(3);
      idx_ready = 1'b0;
      wait_rel(6);
      idx_ready = 1'b1;
      drain();

      // Empty table: busy for cycles 1..9 and never a term.
      push_done(4'd0, 9);
      start_scan(8'h00, 1'b0);
      for (int r = 1; r <= 9; r++) begin
         wait_rel(r);
         chk("empty_busy", {31'b0, busy}, 32'd1);
      end
      wait_rel(10);
      chk("empty_busy_end", {31'b0, busy}, 32'd0);
      drain();

      // Reset during the scan of 8'hAA at cycle 4.
      push_idx(3'd1, 1'b0, 2);
      push_idx(3'd3, 1'b0, 4);
      start_scan(8'hAA, 1'b0);
      wait_rel(4);
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      chk_idle_zero("midreset");
      repeat (10) @(posedge clk);
      #1;
      drain();
      push_idx(3'd1, 1'b0, 2);
      push_idx(3'd3, 1'b0, 4);
      push_idx(3'd5, 1'b0, 6);
      push_idx(3'd7, 1'b1, 8);
      push_done(4'd4, 9);
      start_scan(8'hAA, 1'b0);
      drain();

      // A second start while busy must not disturb the running scan.
      push_idx(3'd0, 1'b0, 1);
      push_idx(3'd2, 1'b0, 3);
      push_idx(3'd6, 1'b0, 7);
      push_idx(3'd7, 1'b1, 8);
      push_done(4'd4, 9);
      start_scan(8'b1100_0101, 1'b0);
      wait_rel(3);
      tt_in = 8'h0F;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
